// File: rtl/lc3b_types.sv
// Shared LC-3b core types: reservation-station numbering and CDB arbitration constants.
package lc3b_types;

  localparam int NUM_STATIONS     = 8;
  localparam int RS_SEL_W         = $clog2(NUM_STATIONS);
  localparam int CDB_STARVE_LIMIT = 4;

  // Global station numbering: ALU stations first, then AGU, then control-flow.
  localparam int RS_ALU_FIRST = 0;
  localparam int RS_ALU_LAST  = 3;
  localparam int RS_AGU_FIRST = 4;
  localparam int RS_AGU_LAST  = 5;
  localparam int RS_CF_FIRST  = 6;
  localparam int RS_CF_LAST   = 7;

  typedef logic [RS_SEL_W-1:0] lc3b_rs_sel;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority search: first set request at or after start, wrapping.
module rr_priority_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    logic [W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // Walk from farthest to nearest so the closest hit to start wins.
    for (int k = N - 1; k >= 0; k--) begin
      cand = W'((int'(start) + k) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Registered round-robin CDB arbiter: LSQ-first priority with a starvation override for stations.
module cdb_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_REQ      = NUM_STATIONS,
  parameter int SEL_W        = $clog2(NUM_REQ),
  parameter int STARVE_LIMIT = CDB_STARVE_LIMIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] complete,
  input  logic               lsq_req,
  output logic [SEL_W-1:0]   selection,
  output logic               sel_load,
  output logic               lsq_grant,
  output logic               starved
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [SEL_W-1:0]   selection_q, selection_d;
  logic               sel_load_q, sel_load_d;
  logic               lsq_grant_q, lsq_grant_d;
  logic               starved_q, starved_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;

  logic [NUM_REQ-1:0] eff_st;
  logic               eff_lsq;
  logic               st_found;
  logic [SEL_W-1:0]   st_idx;
  logic               grant_st, grant_lsq;

  // A requester is still high during its own grant cycle; keep it out of this edge.
  assign eff_st  = complete & ~mask_q;
  assign eff_lsq = lsq_req & ~lsq_grant_q;

  rr_priority_pick #(.N(NUM_REQ), .W(SEL_W)) u_pick (
    .req   (eff_st),
    .start (rr_ptr_q),
    .found (st_found),
    .idx   (st_idx)
  );

  always_comb begin
    grant_st     = st_found && (starved_q || !eff_lsq);
    grant_lsq    = eff_lsq && !grant_st;
    selection_d  = '0;
    sel_load_d   = 1'b0;
    lsq_grant_d  = 1'b0;
    mask_d       = '0;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    if (flush) begin
      starve_cnt_d = '0;
    end else begin
      sel_load_d  = grant_st;
      lsq_grant_d = grant_lsq;
      if (grant_st) begin
        selection_d    = st_idx;
        mask_d[st_idx] = 1'b1;
        rr_ptr_d       = (st_idx == SEL_W'(NUM_REQ - 1)) ? '0 : st_idx + 1'b1;
      end
      if (grant_st || !st_found)
        starve_cnt_d = '0;
      else if (grant_lsq && starve_cnt_q != CNT_W'(STARVE_LIMIT))
        starve_cnt_d = starve_cnt_q + 1'b1;
    end
    starved_d = (starve_cnt_d == CNT_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      selection_q  <= '0;
      sel_load_q   <= 1'b0;
      lsq_grant_q  <= 1'b0;
      starved_q    <= 1'b0;
      rr_ptr_q     <= '0;
      starve_cnt_q <= '0;
      mask_q       <= '0;
    end else begin
      selection_q  <= selection_d;
      sel_load_q   <= sel_load_d;
      lsq_grant_q  <= lsq_grant_d;
      starved_q    <= starved_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      mask_q       <= mask_d;
    end
  end

  assign selection = selection_q;
  assign sel_load  = sel_load_q;
  assign lsq_grant = lsq_grant_q;
  assign starved   = starved_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, reset corner, and random run against a rule-level model.
module tb_cdb_arbiter;
  localparam int NR = 8;

  logic          clk, reset, flush, lsq_req;
  logic [NR-1:0] complete;
  logic [2:0]    sel_a, sel_b;
  logic          sl_a, lg_a, st_a, sl_b, lg_b, st_b;

  int checks = 0;
  int errors = 0;

  cdb_arbiter dut_a (
    .clk(clk), .reset(reset), .flush(flush), .complete(complete), .lsq_req(lsq_req),
    .selection(sel_a), .sel_load(sl_a), .lsq_grant(lg_a), .starved(st_a)
  );

  cdb_arbiter #(.STARVE_LIMIT(1)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .complete(complete), .lsq_req(lsq_req),
    .selection(sel_b), .sel_load(sl_b), .lsq_grant(lg_b), .starved(st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: rr pointer, starvation count, station granted last cycle (-1 none),
  // whether the LSQ was granted last cycle, and the visible outputs.
  typedef struct {
    int rr; int cnt; int last; bit lgr;
    bit sl; int sel; bit lg; bit stv;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mreset();
    mdl_t m;
    m.rr = 0; m.cnt = 0; m.last = -1; m.lgr = 0;
    m.sl = 0; m.sel = 0; m.lg = 0; m.stv = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int limit, logic [NR-1:0] c, bit l, bit f);
    mdl_t n;
    int pick;
    int i;
    bit el;
    n = m;
    n.sl = 0; n.sel = 0; n.lg = 0; n.last = -1;
    if (f) begin
      n.cnt = 0; n.lgr = 0; n.stv = 0;
      return n;
    end
    pick = -1;
    for (int k = 0; k < NR; k++) begin
      i = (m.rr + k) % NR;
      if (pick < 0 && c[i] && i != m.last) pick = i;
    end
    el = l && !m.lgr;
    if (pick >= 0 && (m.stv || !el)) begin
      n.sl = 1; n.sel = pick; n.last = pick; n.rr = (pick + 1) % NR; n.cnt = 0;
    end else if (el) begin
      n.lg = 1;
      if (pick < 0) n.cnt = 0;
      else n.cnt = (m.cnt < limit) ? m.cnt + 1 : limit;
    end else begin
      n.cnt = 0;
    end
    n.lgr = n.lg;
    n.stv = (n.cnt == limit);
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [NR-1:0] c, input bit l, input bit f);
    complete = c; lsq_req = l; flush = f;
    @(posedge clk);
    ma = mstep(ma, 4, c, l, f);
    mb = mstep(mb, 1, c, l, f);
    #1;
  endtask

  typedef struct {
    logic [NR-1:0] c; bit l; bit f;
    bit sl; int sel; bit lg; bit stv; bit stv1;
  } vec_t;

  vec_t tv[20];

  initial begin
    tv[0]  = '{8'h04, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{8'h04, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{8'h81, 1'b0, 1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{8'h81, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{8'h01, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{8'h03, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{8'h03, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tv[10] = '{8'h02, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1};
    tv[11] = '{8'h02, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    tv[12] = '{8'h02, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    tv[13] = '{8'h02, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    tv[14] = '{8'h20, 1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0};
    tv[15] = '{8'h20, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tv[16] = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tv[17] = '{8'hFF, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tv[18] = '{8'hFF, 1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b0};
    tv[19] = '{8'hFF, 1'b0, 1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; flush = 1'b0; lsq_req = 1'b0; complete = '0;
    ma = mreset(); mb = mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel_load", sl_a, 0);
    chk("rst_lsq_grant", lg_a, 0);
    chk("rst_selection", sel_a, 0);
    chk("rst_starved", st_a, 0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cyc(tv[i].c, tv[i].l, tv[i].f);
      chk($sformatf("v%0d_sel_load", i), sl_a, tv[i].sl);
      chk($sformatf("v%0d_lsq_grant", i), lg_a, tv[i].lg);
      if (tv[i].sl) chk($sformatf("v%0d_selection", i), sel_a, tv[i].sel);
      chk($sformatf("v%0d_starved", i), st_a, tv[i].stv);
      chk($sformatf("v%0d_starved_lim1", i), st_b, tv[i].stv1);
      chk($sformatf("v%0d_mutex", i), sl_a & lg_a, 0);
    end

    // Reset lands in the middle of a grant pulse.
    cyc(8'h01, 1'b0, 1'b0);
    chk("pre_rst_sel_load", sl_a, 1);
    chk("pre_rst_selection", sel_a, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_sel_load", sl_a, 0);
    chk("async_rst_selection", sel_a, 0);
    chk("async_rst_lsq_grant", lg_a, 0);
    chk("async_rst_sel_load_b", sl_b, 0);
    ma = mreset(); mb = mreset();
    complete = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(8'h00, 1'b0, 1'b0);
    chk("post_rst_sel_load", sl_a, 0);
    chk("post_rst_lsq_grant", lg_a, 0);
    cyc(8'h81, 1'b0, 1'b0);
    chk("post_rst_rr_sel", sel_a, 0);

    for (int i = 0; i < 400; i++) begin
      cyc(NR'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
      chk("rnd_a_sel_load", sl_a, ma.sl);
      chk("rnd_a_lsq_grant", lg_a, ma.lg);
      chk("rnd_a_selection", sel_a, ma.sel);
      chk("rnd_a_starved", st_a, ma.stv);
      chk("rnd_b_sel_load", sl_b, mb.sl);
      chk("rnd_b_lsq_grant", lg_b, mb.lg);
      chk("rnd_b_selection", sel_b, mb.sel);
      chk("rnd_b_starved", st_b, mb.stv);
      chk("rnd_mutex", (sl_a & lg_a) | (sl_b & lg_b), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
